// File: rtl/idma_init_read_gen.sv
// iDMA INIT read task: generates zero/const/incrementing/LFSR beat data internally.
// Optional macro IDMA_INIT_READ_LFSR_EN enables the LFSR pattern; otherwise mode 3 returns zeros with SLVERR.
module idma_init_read_gen #(
  parameter  int unsigned StrbWidth   = 16,
  parameter  int unsigned LenWidth    = 16,
  parameter  int unsigned SeedWidth   = 32,
  localparam int unsigned OffsetWidth = $clog2(StrbWidth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               read_meta_mode_i,
  input  logic [SeedWidth-1:0]     read_meta_seed_i,
  input  logic [LenWidth-1:0]      read_meta_beats_i,
  input  logic                     read_meta_valid_i,
  output logic                     read_meta_ready_o,
  input  logic [OffsetWidth-1:0]   r_dp_offset_i,
  input  logic [OffsetWidth-1:0]   r_dp_tailer_i,
  input  logic [OffsetWidth-1:0]   r_dp_shift_i,
  input  logic                     r_dp_valid_i,
  output logic                     r_dp_ready_o,
  output logic [1:0]               r_dp_resp_o,
  output logic                     r_dp_first_o,
  output logic                     r_dp_last_o,
  output logic                     r_dp_valid_o,
  input  logic                     r_dp_ready_i,
  output logic [8*StrbWidth-1:0]   buffer_in_o,
  output logic [StrbWidth-1:0]     buffer_in_valid_o,
  input  logic [StrbWidth-1:0]     buffer_in_ready_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_INCR  = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [7:0]           const_q;
  logic [7:0]           base_q;
  logic [LenWidth-1:0]  beats_q;
  logic [LenWidth-1:0]  count_q;
  logic [SeedWidth-1:0] lfsr_word;

  logic [StrbWidth-1:0]   head_mask, tail_mask, lin_mask, mask;
  logic [2*StrbWidth-1:0] rot_mask;
  logic [8*StrbWidth-1:0] beat_data;
  logic                   in_ready, fire, last_beat, meta_ready, meta_load;

  // Byte-enable mask of the beat in buffer lane order.
  // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
  always_comb begin
    head_mask = {StrbWidth{1'b1}} << r_dp_offset_i;
    tail_mask = {StrbWidth{1'b1}};
    if (r_dp_tailer_i != '0) begin
      tail_mask = {StrbWidth{1'b1}} >> (StrbWidth - 32'(r_dp_tailer_i));
    end
    lin_mask = head_mask & tail_mask;
    rot_mask = {lin_mask, lin_mask} >> r_dp_shift_i;
    mask     = rot_mask[StrbWidth-1:0];
  end

  // All-or-nothing push: every enabled lane must be ready at once.
  assign in_ready   = &(buffer_in_ready_i | ~mask);
  assign fire       = (state_q == GEN) & ~rst_i & r_dp_valid_i & r_dp_ready_i & in_ready;
  assign last_beat  = (count_q == beats_q);
  assign meta_ready = ~rst_i & ((state_q == IDLE) | (fire & last_beat));
  assign meta_load  = meta_ready & read_meta_valid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (meta_load) state_d = GEN;
      GEN:     if (fire && last_beat && !meta_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_ZERO;
      const_q <= '0;
      base_q  <= '0;
      beats_q <= '0;
      count_q <= '0;
    end else if (meta_load) begin
      mode_q  <= mode_e'(read_meta_mode_i);
      const_q <= read_meta_seed_i[7:0];
      base_q  <= read_meta_seed_i[7:0];
      beats_q <= read_meta_beats_i;
      count_q <= '0;
    end else if (fire) begin
      count_q <= count_q + LenWidth'(1);
      base_q  <= base_q + 8'(StrbWidth);
    end
  end

`ifdef IDMA_INIT_READ_LFSR_EN
  localparam logic [SeedWidth-1:0] LfsrPoly = SeedWidth'(32'h8020_0003);

  logic [SeedWidth-1:0] lfsr_q;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= '0;
    end else if (meta_load) begin
      lfsr_q <= (read_meta_seed_i == '0) ? SeedWidth'(1) : read_meta_seed_i;
    end else if (fire) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrPoly) : (lfsr_q >> 1);
    end
  end

  assign lfsr_word   = lfsr_q;
  assign r_dp_resp_o = 2'b00;
`else
  logic [SeedWidth-9:0] unused_seed_hi;

  assign unused_seed_hi = read_meta_seed_i[SeedWidth-1:8];
  assign lfsr_word      = '0;
  assign r_dp_resp_o    = ((state_q == GEN) && (mode_q == MODE_LFSR)) ? 2'b10 : 2'b00;
`endif

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      case (mode_q)
        MODE_CONST: beat_data[8*i +: 8] = const_q;
        MODE_INCR:  beat_data[8*i +: 8] = base_q + 8'(i);
        MODE_LFSR:  beat_data[8*i +: 8] = lfsr_word[8*(i%4) +: 8];
        default:    beat_data[8*i +: 8] = 8'h00;
      endcase
    end
  end

  assign read_meta_ready_o = meta_ready;
  assign r_dp_ready_o      = fire;
  assign r_dp_valid_o      = fire;
  assign r_dp_first_o      = (count_q == '0);
  assign r_dp_last_o       = last_beat;
  assign buffer_in_o       = beat_data;
  assign buffer_in_valid_o = fire ? mask : '0;
  assign busy_o            = ~rst_i & (state_q == GEN);

endmodule
